window3x3_stream: RTL

Parametrised streaming 3×3 neighbourhood generator for the image-convolution datapath. It accepts a raster-order pixel stream with valid/ready, holds a four-row line ring instead of a full frame buffer, and emits one 9-tap window per image pixel with border handling, plus row/column tags. It feeds the convolution kernel and replaces the frame-sized buffer-and-index approach with backpressure-aware streaming of any image size.

---
 rtl/win3_pkg.sv | 29 ++
 rtl/window3x3_stream_if.sv | 32 +++
 rtl/win3_line_ring.sv | 31 +++
 rtl/window3x3_stream.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/win3_pkg.sv
// win3_pkg: shared constants, FSM state type and coordinate clamp
// used by window3x3_stream and its line ring.
package win3_pkg;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;
  localparam int NTAPS  = 9;

  localparam int RING_ROWS = 4;

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/window3x3_stream_if.sv
// window3x3_stream_if: pixel-in / window-out valid-ready bundle.
// slave = the window generator, master = producer/consumer side.
interface window3x3_stream_if #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [PIX_W-1:0]   in_pixel;
  logic               in_valid;
  logic               in_ready;
  logic [9*PIX_W-1:0] out_window;
  logic [RW-1:0]      out_row;
  logic [CW-1:0]      out_col;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_window, out_row,
    output out_col, out_last, out_valid
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_window, out_row,
    input  out_col, out_last, out_valid
  );
endinterface

// File: rtl/win3_line_ring.sv
// win3_line_ring: RING_ROWS x IMG_W pixel store, one write port and
// nine combinational (slot, column) read ports. No reset on storage.
module win3_line_ring
  import win3_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  localparam int CW = $clog2(IMG_W)
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [1:0]                   wr_slot_i,
  input  logic [CW-1:0]                wr_col_i,
  input  logic [PIX_W-1:0]             wr_data_i,
  input  logic [NTAPS-1:0][1:0]        rd_slot_i,
  input  logic [NTAPS-1:0][CW-1:0]     rd_col_i,
  output logic [NTAPS-1:0][PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [RING_ROWS][IMG_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
  end

  always_comb begin
    for (int t = 0; t < NTAPS; t++)
      rd_data_o[t] = mem_q[rd_slot_i[t]][rd_col_i[t]];
  end

endmodule

// File: rtl/window3x3_stream.sv
// window3x3_stream: raster pixel stream in, one 3x3 window per pixel out
// (bus: window3x3_stream_if.slave; clk, sync active-high reset).
// Border taps replicate the edge; WIN3_ZERO_PAD_EN makes them zero.
module window3x3_stream
  import win3_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input logic                clk,
  input logic                reset,
  window3x3_stream_if.slave  s
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  state_e state_q, state_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] o_row_q, o_row_d;
  logic [CW-1:0] o_col_q, o_col_d;
  logic vld_q, vld_d;
  logic [NTAPS-1:0][PIX_W-1:0] win_q, win_d;

  logic in_fire, out_fire, o_last;
  logic [RW-1:0] cand_r, er;
  logic [CW-1:0] cand_c, ec;
  logic cand_wrap, elig, load;
  logic [NTAPS-1:0][1:0] rd_slot;
  logic [NTAPS-1:0][CW-1:0] rd_col;
  logic [NTAPS-1:0][PIX_W-1:0] rd_data;
  logic [NTAPS-1:0][PIX_W-1:0] taps;
`ifdef WIN3_ZERO_PAD_EN
  logic [NTAPS-1:0] oob;
`endif

  // Input may run at most two rows ahead of the output head so that
  // the slot of row o_row-1 is never overwritten.
  assign s.in_ready = !reset && (state_q == RUN) &&
    ({2'b0, in_row_q} <= {2'b0, o_row_q} + (RW+2)'(2));

  assign in_fire  = s.in_valid && s.in_ready;
  assign out_fire = vld_q && s.out_ready;
  assign o_last   = (o_row_q == ROW_LAST) && (o_col_q == COL_LAST);

  assign s.out_valid  = vld_q;
  assign s.out_window = win_q;
  assign s.out_row    = o_row_q;
  assign s.out_col    = o_col_q;
  assign s.out_last   = vld_q && o_last;

  // Candidate = next window to load: head itself when empty,
  // otherwise the one after the window being presented.
  always_comb begin
    cand_r = o_row_q;
    cand_c = o_col_q;
    if (vld_q) begin
      if (o_col_q == COL_LAST) begin
        cand_c = '0;
        cand_r = (o_row_q == ROW_LAST) ? '0 : o_row_q + 1'b1;
      end else begin
        cand_c = o_col_q + 1'b1;
      end
    end
  end

  assign cand_wrap = vld_q && o_last;
  assign er = (cand_r == ROW_LAST) ? cand_r : cand_r + 1'b1;
  assign ec = (cand_c == COL_LAST) ? cand_c : cand_c + 1'b1;

  // In DRAIN every remaining window of the frame is available; the
  // input counters already point at the next frame.
  assign elig = (in_row_q > er) ||
                ((in_row_q == er) && (in_col_q > ec)) ||
                ((state_q == DRAIN) && !cand_wrap);
  assign load = elig && (!vld_q || s.out_ready);

  always_comb begin
    int rr, cc, t;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        t  = (dr + 1) * 3 + (dc + 1);
        rr = int'(cand_r) + dr;
        cc = int'(cand_c) + dc;
        rd_slot[t] = 2'(clamp(rr, IMG_H - 1) % RING_ROWS);
        rd_col[t]  = CW'(clamp(cc, IMG_W - 1));
`ifdef WIN3_ZERO_PAD_EN
        oob[t] = (rr < 0) || (rr > IMG_H - 1) ||
                 (cc < 0) || (cc > IMG_W - 1);
`endif
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NTAPS; t++) begin
`ifdef WIN3_ZERO_PAD_EN
      taps[NTAPS-1-t] = oob[t] ? '0 : rd_data[t];
`else
      taps[NTAPS-1-t] = rd_data[t];
`endif
    end
  end

  win3_line_ring #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_ring (
    .clk       (clk),
    .we_i      (in_fire),
    .wr_slot_i (2'(int'(in_row_q) % RING_ROWS)),
    .wr_col_i  (in_col_q),
    .wr_data_i (s.in_pixel),
    .rd_slot_i (rd_slot),
    .rd_col_i  (rd_col),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    in_row_d = in_row_q;
    in_col_d = in_col_q;
    o_row_d  = o_row_q;
    o_col_d  = o_col_q;
    vld_d    = vld_q;
    win_d    = win_q;
    if (in_fire) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
        if (in_row_q == ROW_LAST) state_d = DRAIN;
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end
    if (out_fire) begin
      o_row_d = cand_r;
      o_col_d = cand_c;
      vld_d   = 1'b0;
      if (o_last) state_d = RUN;
    end
    if (load) begin
      vld_d = 1'b1;
      win_d = taps;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      in_row_q <= '0;
      in_col_q <= '0;
      o_row_q  <= '0;
      o_col_q  <= '0;
      vld_q    <= 1'b0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_row_q <= in_row_d;
      in_col_q <= in_col_d;
      o_row_q  <= o_row_d;
      o_col_q  <= o_col_d;
      vld_q    <= vld_d;
      win_q    <= win_d;
    end
  end

endmodule
